fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO; next generation of the width-expanded FIFO. One storage array of arbitrary WIDTH/DEPTH replaces side-by-side slice instances.
Adds a single exact fill counter, programmable almost-full/almost-empty flags, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
Sits between producer/consumer blocks in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; power of 2, >=2
AF_LEVEL, DEPTH-2, almost_full asserted when fillcount >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when fillcount <= AE_LEVEL
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
data_in  in  WIDTH  write data
put  in  1  write request
get  in  1  read request
data_out  out  WIDTH  read data
fillcount  out  CW  entries held; CW = clog2(DEPTH)+1
empty  out  1  fillcount == 0
full  out  1  fillcount == DEPTH
almost_empty  out  1  fillcount <= AE_LEVEL
almost_full  out  1  fillcount >= AF_LEVEL
overflow  out  1  one-cycle pulse: put rejected
underflow  out  1  one-cycle pulse: get rejected

Behaviour:
- Reset: clk edge with reset==0 clears wr_ptr, rd_ptr, fillcount; data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage array not reset. Reset overrides put/get in the same cycle; mid-operation reset discards contents.
- Accept rules (evaluated on pre-edge state):
  - wr_en = put & (!full | get).
  - rd_en = get & !empty.
- Full with put&get: both accepted, count unchanged.
- Empty with put&get: only the put is accepted; underflow pulses.
- put & full & !get: write dropped, contents unchanged, overflow=1 for one cycle.
- get & empty: underflow=1 for one cycle, data_out holds.
- Pointers: clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- fillcount: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither.
- All flags are registered; they reflect the post-edge fillcount in the same cycle it updates. No combinational path from put/get to any output.
- Read latency, FWFT=0: on rd_en, data_out <= mem[rd_ptr] at that edge, so it is valid the cycle after get. data_out holds its value otherwise.
- Read latency, FWFT=1: data_out = mem[rd_ptr] continuously; it is valid whenever empty==0. get pops the shown word. A word written into an empty FIFO appears on data_out the cycle after the write edge. data_out is undefined-but-stable when empty; bench must not check it then.
- Elaboration checks: DEPTH not a power of 2, AF_LEVEL>DEPTH, or AE_LEVEL>=DEPTH is an error.

Decomposition:
- Package fifo_pkg: clog2 function, derived widths (PW=clog2(DEPTH), CW=PW+1), FWFT mode constants.
- One sub-module fifo_sync_ctrl: pointers, fillcount, all flags, overflow/underflow. Exports wr_en, rd_en, wr_ptr, rd_ptr.
- Top holds the storage array and the data_out path.

Test Plan:
- Reset then idle, WIDTH=32, DEPTH=8 -> fillcount=0, empty=1, almost_empty=1, full=0, data_out=0.
- Write 8 words 0xA0..0xA7, then a 9th put -> full=1, fillcount=8, almost_full=1 from count 6. The 9th put pulses overflow one cycle; a later drain returns A0..A7 in order, with 0xA8 absent.
- Full FIFO with put=1, get=1 for 4 cycles -> fillcount stays 8, overflow never pulses. Reads return A0..A3; writes fill 4 more slots across the pointer wrap.
- get on empty -> underflow pulses one cycle, fillcount stays 0. Same-cycle put&get on empty -> fillcount=1, underflow=1.
- FWFT=1: put 0x1234 into empty FIFO -> data_out=0x1234 and empty=0 the next cycle with no get. get pops it, and empty=1 the following cycle.
- Reset asserted (reset=0) with 5 entries while put=1 -> next cycle fillcount=0, empty=1, data_out=0, and the write is not stored.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_pkg : shared widths and read-mode constants for fifo_sync   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Ceiling log2 usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_param_if : producer/consumer bus of fifo_sync_param    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_in;
  logic             put;
  logic             get;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    fillcount;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, put, get,
    input  data_out, fillcount, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  data_in, put, get,
    output data_out, fillcount, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_ctrl : pointers, fill counter and registered flags     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int PW       = clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          i_put,
  input  wire logic          i_get,
  output logic               o_wr_en,
  output logic               o_rd_en,
  output logic [PW-1:0]      o_wr_ptr,
  output logic [PW-1:0]      o_rd_ptr,
  output logic [CW-1:0]      o_fillcount,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_almost_empty,
  output logic               o_almost_full,
  output logic               o_overflow,
  output logic               o_underflow
);
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_empty, r_full, r_ae, r_af, r_ovf, r_udf;
  logic          w_wr_en, w_rd_en;

  // Enables are gated by reset so the storage array ignores a put during reset.
  assign w_wr_en = reset & i_put & (~r_full | i_get);
  assign w_rd_en = reset & i_get & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ae     <= 1'b1;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_ae    <= (int'(w_count_nxt) <= AE_LEVEL);
      r_af    <= (int'(w_count_nxt) >= AF_LEVEL);
      r_ovf   <= i_put & r_full & ~i_get;
      r_udf   <= i_get & r_empty;
    end
  end

  assign o_wr_en        = w_wr_en;
  assign o_rd_en        = w_rd_en;
  assign o_wr_ptr       = r_wr_ptr;
  assign o_rd_ptr       = r_rd_ptr;
  assign o_fillcount    = r_count;
  assign o_empty        = r_empty;
  assign o_full         = r_full;
  assign o_almost_empty = r_ae;
  assign o_almost_full  = r_af;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;
endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_param : single-clock FIFO, storage array and read path |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_OFF
) (
  input wire logic          clk,
  input wire logic          reset,
  fifo_sync_param_if.slave  bus
);
  localparam int PW = clog2(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("fifo_sync_param: AE_LEVEL must be below DEPTH");
    end
  endgenerate

  logic             w_wr_en, w_rd_en;
  logic [PW-1:0]    w_wr_ptr, w_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  fifo_sync_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .i_put          (bus.put),
    .i_get          (bus.get),
    .o_wr_en        (w_wr_en),
    .o_rd_en        (w_rd_en),
    .o_wr_ptr       (w_wr_ptr),
    .o_rd_ptr       (w_rd_ptr),
    .o_fillcount    (bus.fillcount),
    .o_empty        (bus.empty),
    .o_full         (bus.full),
    .o_almost_empty (bus.almost_empty),
    .o_almost_full  (bus.almost_full),
    .o_overflow     (bus.overflow),
    .o_underflow    (bus.underflow)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= bus.data_in;
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is always visible; meaningless while empty.
      assign bus.data_out = r_mem[w_rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (!reset)       r_dout <= '0;
        else if (w_rd_en) r_dout <= r_mem[w_rd_ptr];
      end
      assign bus.data_out = r_dout;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_sync_param : directed self-checking bench                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(32), .DEPTH(8)) bus_a ();
  fifo_sync_param_if #(.WIDTH(32), .DEPTH(8)) bus_b ();

  fifo_sync_param #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  fifo_sync_param #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.put = 0; bus_a.get = 0; bus_a.data_in = '0;
    bus_b.put = 0; bus_b.get = 0; bus_b.data_in = '0;
    step(); step();
    reset = 1'b1;
    step();
    n_tests++;
    if (bus_a.fillcount !== 4'd0 || bus_a.empty !== 1'b1 || bus_a.almost_empty !== 1'b1 ||
        bus_a.full !== 1'b0 || bus_a.almost_full !== 1'b0 || bus_a.data_out !== 32'h0 ||
        bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d e=%b ae=%b f=%b af=%b d=%h ov=%b un=%b, expected 0 1 1 0 0 0 0 0",
               bus_a.fillcount, bus_a.empty, bus_a.almost_empty, bus_a.full,
               bus_a.almost_full, bus_a.data_out, bus_a.overflow, bus_a.underflow);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) begin
      bus_a.put = 1; bus_a.data_in = 32'hA0 + i;
      step();
      n_tests++;
      if (bus_a.fillcount !== 4'(i + 1) || bus_a.almost_full !== (i + 1 >= 6) ||
          bus_a.almost_empty !== (i + 1 <= 2) || bus_a.full !== (i + 1 == 8) ||
          bus_a.empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: cnt=%0d af=%b ae=%b f=%b e=%b, expected cnt=%0d af=%b ae=%b f=%b e=0",
                 i, bus_a.fillcount, bus_a.almost_full, bus_a.almost_empty, bus_a.full,
                 bus_a.empty, i + 1, (i + 1 >= 6), (i + 1 <= 2), (i + 1 == 8));
      end
    end
    bus_a.data_in = 32'hA8;
    step();
    n_tests++;
    if (bus_a.overflow !== 1'b1 || bus_a.fillcount !== 4'd8 || bus_a.full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse: ov=%b cnt=%0d f=%b, expected 1 8 1",
               bus_a.overflow, bus_a.fillcount, bus_a.full);
    end
    bus_a.put = 0;
    step();
    n_tests++;
    if (bus_a.overflow !== 1'b0 || bus_a.fillcount !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow_clear: ov=%b cnt=%0d, expected 0 8", bus_a.overflow, bus_a.fillcount);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus_a.put = 1; bus_a.get = 1; bus_a.data_in = 32'hB0 + i;
      step();
      n_tests++;
      if (bus_a.fillcount !== 4'd8 || bus_a.overflow !== 1'b0 || bus_a.full !== 1'b1 ||
          bus_a.data_out !== 32'hA0 + i) begin
        n_fail++;
        $display("FAIL b2b_%0d: cnt=%0d ov=%b f=%b d=%h, expected 8 0 1 %h",
                 i, bus_a.fillcount, bus_a.overflow, bus_a.full, bus_a.data_out, 32'hA0 + i);
      end
    end
    bus_a.put = 0; bus_a.get = 0;
  endtask

  task automatic test_drain();
    logic [31:0] exp_q [8];
    exp_q = '{32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
    for (int i = 0; i < 8; i++) begin
      bus_a.get = 1;
      step();
      n_tests++;
      if (bus_a.data_out !== exp_q[i] || bus_a.fillcount !== 4'(7 - i) ||
          bus_a.empty !== (i == 7)) begin
        n_fail++;
        $display("FAIL drain_%0d: d=%h cnt=%0d e=%b, expected %h %0d %b",
                 i, bus_a.data_out, bus_a.fillcount, bus_a.empty, exp_q[i], 7 - i, (i == 7));
      end
    end
    bus_a.get = 0;
  endtask

  task automatic test_underflow();
    bus_a.get = 1;
    step();
    n_tests++;
    if (bus_a.underflow !== 1'b1 || bus_a.fillcount !== 4'd0 || bus_a.data_out !== 32'hB3) begin
      n_fail++;
      $display("FAIL underflow_pulse: un=%b cnt=%0d d=%h, expected 1 0 b3",
               bus_a.underflow, bus_a.fillcount, bus_a.data_out);
    end
    bus_a.get = 0;
    step();
    n_tests++;
    if (bus_a.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: un=%b, expected 0", bus_a.underflow);
    end
    bus_a.put = 1; bus_a.get = 1; bus_a.data_in = 32'hC5;
    step();
    n_tests++;
    if (bus_a.fillcount !== 4'd1 || bus_a.underflow !== 1'b1 || bus_a.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_put_get: cnt=%0d un=%b e=%b, expected 1 1 0",
               bus_a.fillcount, bus_a.underflow, bus_a.empty);
    end
    bus_a.put = 0; bus_a.get = 1;
    step();
    n_tests++;
    if (bus_a.data_out !== 32'hC5 || bus_a.fillcount !== 4'd0 || bus_a.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_put_get_read: d=%h cnt=%0d un=%b, expected c5 0 0",
               bus_a.data_out, bus_a.fillcount, bus_a.underflow);
    end
    bus_a.get = 0;
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 5; i++) begin
      bus_a.put = 1; bus_a.data_in = 32'hD0 + i;
      step();
    end
    bus_a.put = 0; bus_a.get = 1;
    step();
    n_tests++;
    if (bus_a.data_out !== 32'hD0 || bus_a.fillcount !== 4'd4) begin
      n_fail++;
      $display("FAIL midop_pre: d=%h cnt=%0d, expected d0 4", bus_a.data_out, bus_a.fillcount);
    end
    bus_a.get = 0; bus_a.put = 1; bus_a.data_in = 32'hD5;
    step();
    bus_a.data_in = 32'hEE;
    reset = 1'b0;
    step();
    reset = 1'b1; bus_a.put = 0;
    n_tests++;
    if (bus_a.fillcount !== 4'd0 || bus_a.empty !== 1'b1 || bus_a.data_out !== 32'h0 ||
        bus_a.almost_empty !== 1'b1 || bus_a.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: cnt=%0d e=%b d=%h ae=%b af=%b, expected 0 1 0 1 0",
               bus_a.fillcount, bus_a.empty, bus_a.data_out, bus_a.almost_empty, bus_a.almost_full);
    end
    bus_a.put = 1; bus_a.data_in = 32'hF0;
    step();
    bus_a.put = 0; bus_a.get = 1;
    step();
    bus_a.get = 0;
    n_tests++;
    if (bus_a.data_out !== 32'hF0 || bus_a.fillcount !== 4'd0) begin
      n_fail++;
      $display("FAIL midop_after: d=%h cnt=%0d, expected f0 0", bus_a.data_out, bus_a.fillcount);
    end
  endtask

  task automatic test_fwft();
    bus_b.put = 1; bus_b.data_in = 32'h1234;
    step();
    bus_b.put = 0;
    n_tests++;
    if (bus_b.empty !== 1'b0 || bus_b.data_out !== 32'h1234) begin
      n_fail++;
      $display("FAIL fwft_show: e=%b d=%h, expected 0 1234", bus_b.empty, bus_b.data_out);
    end
    step();
    n_tests++;
    if (bus_b.empty !== 1'b0 || bus_b.data_out !== 32'h1234 || bus_b.fillcount !== 4'd1) begin
      n_fail++;
      $display("FAIL fwft_hold: e=%b d=%h cnt=%0d, expected 0 1234 1",
               bus_b.empty, bus_b.data_out, bus_b.fillcount);
    end
    bus_b.get = 1;
    step();
    bus_b.get = 0;
    n_tests++;
    if (bus_b.empty !== 1'b1 || bus_b.fillcount !== 4'd0) begin
      n_fail++;
      $display("FAIL fwft_pop: e=%b cnt=%0d, expected 1 0", bus_b.empty, bus_b.fillcount);
    end
    bus_b.put = 1; bus_b.data_in = 32'h5678;
    step();
    bus_b.data_in = 32'h9ABC;
    step();
    bus_b.put = 0; bus_b.get = 1;
    n_tests++;
    if (bus_b.data_out !== 32'h5678 || bus_b.fillcount !== 4'd2) begin
      n_fail++;
      $display("FAIL fwft_head: d=%h cnt=%0d, expected 5678 2", bus_b.data_out, bus_b.fillcount);
    end
    step();
    bus_b.get = 0;
    n_tests++;
    if (bus_b.data_out !== 32'h9ABC || bus_b.fillcount !== 4'd1) begin
      n_fail++;
      $display("FAIL fwft_next: d=%h cnt=%0d, expected 9abc 1", bus_b.data_out, bus_b.fillcount);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_back_to_back();
    test_drain();
    test_underflow();
    test_reset_midop();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
